// File: rtl/rx_frame_buffer.sv
// rx_frame_buffer
//
// Receive-side frame store. Bytes are announced by a toggle on count_addr and
// are written into a circular byte buffer. At end of frame a good frame is
// committed (its length is queued in a 4-entry length FIFO) and a bad frame
// is discarded by rewinding the write pointer to the last commit point.
// Committed frames are read out as length-tagged byte streams.
//
// Optional feature macro: RX_FRAME_STATS_EN
//   defined   -> frames_ok / frames_dropped are 16-bit saturating counters
//   undefined -> both outputs are tied to 0
//
// Ports
//   clk            : the only clock
//   reset_n        : asynchronous, active-low reset
//   count_addr     : toggles once per received byte
//   data           : received byte, valid in the cycle count_addr toggled
//   receive_tx     : high during frame reception, falling edge = end of frame
//   crc_correct    : FCS result, sampled when the receive_tx fall is seen
//   rd_en          : reader requests the next byte of the head frame
//   frame_avail    : at least one committed frame is queued
//   frame_len      : length of the head frame (0 when nothing is queued)
//   rd_data        : read byte, registered
//   rd_valid       : rd_data is valid this cycle
//   rd_last        : rd_data is the final byte of its frame
//   frames_ok      : good-frame counter
//   frames_dropped : dropped-frame counter

module rx_frame_buffer #(
    parameter int ADDR_W  = 11,
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        count_addr,
    input  logic [7:0]  data,
    input  logic        receive_tx,
    input  logic        crc_correct,
    input  logic        rd_en,
    output logic        frame_avail,
    output logic [10:0] frame_len,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    output logic        rd_last,
    output logic [15:0] frames_ok,
    output logic [15:0] frames_dropped
);

    localparam int              DEPTH    = 1 << ADDR_W;
    localparam int              LF_DEPTH = 4;
    localparam logic [ADDR_W:0] DEPTH_P  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [10:0]     MIN_L    = 11'(MIN_LEN);
    localparam logic [10:0]     MAX_L    = 11'(MAX_LEN);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RECV = 2'd1,
        S_END  = 2'd2
    } state_t;

    state_t state_reg, state_next;

    // Input edge detection
    logic ca_q, rtx_q;
    logic stb, rise, fall;

    assign stb  = count_addr ^ ca_q;
    assign rise = receive_tx & ~rtx_q;
    assign fall = ~receive_tx & rtx_q;

    // Write side
    logic [ADDR_W:0] wr_ptr_reg, commit_ptr_reg, rd_ptr_reg;
    logic [ADDR_W:0] free;
    logic [10:0]     len_reg;
    logic            ovf_reg, crc_reg;
    logic            wr_en, ovf_set, good, bad;

    // Length FIFO
    logic [1:0]  lf_wr_reg, lf_rd_reg;
    logic [2:0]  lf_cnt_reg;
    logic        lf_full, push, pop;
    logic [10:0] lf_q [LF_DEPTH];
    logic [10:0] head_len;

    // Read side
    logic [10:0] rd_cnt_reg;
    logic        rd_acc, rd_end;

    logic [7:0] mem [DEPTH];

    // Occupancy includes committed and in-flight bytes, so an in-progress
    // frame can never overwrite data the reader has not consumed yet.
    assign free    = DEPTH_P - (wr_ptr_reg - rd_ptr_reg);
    assign lf_full = (lf_cnt_reg == 3'd4);

    // ------------------------------------------------------------------
    // Write FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        wr_en      = 1'b0;
        ovf_set    = 1'b0;
        good       = 1'b0;
        bad        = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (rise) begin
                    state_next = S_RECV;
                end
            end
            S_RECV: begin
                // A strobe in the same cycle as the fall is still stored.
                if (stb) begin
                    if ((free == '0) || (len_reg == MAX_L)) begin
                        ovf_set = 1'b1;
                    end else begin
                        wr_en = 1'b1;
                    end
                end
                if (fall) begin
                    state_next = S_END;
                end
            end
            S_END: begin
                if (crc_reg && !ovf_reg && (len_reg >= MIN_L) && !lf_full) begin
                    good = 1'b1;
                end else begin
                    bad = 1'b1;
                end
                // A frame start seen during the decision cycle is not lost.
                state_next = rise ? S_RECV : S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ca_q           <= 1'b0;
            rtx_q          <= 1'b0;
            wr_ptr_reg     <= '0;
            commit_ptr_reg <= '0;
            len_reg        <= '0;
            ovf_reg        <= 1'b0;
            crc_reg        <= 1'b0;
        end else begin
            ca_q  <= count_addr;
            rtx_q <= receive_tx;
            // END still sees the old len/ovf; the clear lands after the decision.
            if (state_reg != S_RECV) begin
                len_reg <= '0;
                ovf_reg <= 1'b0;
            end
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
                len_reg    <= len_reg + 11'd1;
            end
            if (ovf_set) begin
                ovf_reg <= 1'b1;
            end
            if ((state_reg == S_RECV) && fall) begin
                crc_reg <= crc_correct;
            end
            if (good) begin
                commit_ptr_reg <= wr_ptr_reg;
            end
            if (bad) begin
                wr_ptr_reg <= commit_ptr_reg;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg[ADDR_W-1:0]] <= data;
        end
    end

    // ------------------------------------------------------------------
    // Length FIFO
    // ------------------------------------------------------------------
    assign push = good;
    assign pop  = rd_end;

    for (genvar gi = 0; gi < LF_DEPTH; gi++) begin : g_lf
        logic [10:0] entry_reg;
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                entry_reg <= '0;
            end else if (push && (lf_wr_reg == 2'(gi))) begin
                entry_reg <= len_reg;
            end
        end
        assign lf_q[gi] = entry_reg;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lf_wr_reg  <= '0;
            lf_rd_reg  <= '0;
            lf_cnt_reg <= '0;
        end else begin
            if (push) begin
                lf_wr_reg <= lf_wr_reg + 2'd1;
            end
            if (pop) begin
                lf_rd_reg <= lf_rd_reg + 2'd1;
            end
            case ({push, pop})
                2'b10:   lf_cnt_reg <= lf_cnt_reg + 3'd1;
                2'b01:   lf_cnt_reg <= lf_cnt_reg - 3'd1;
                default: lf_cnt_reg <= lf_cnt_reg;
            endcase
        end
    end

    assign head_len    = lf_q[lf_rd_reg];
    assign frame_avail = (lf_cnt_reg != 3'd0);
    assign frame_len   = frame_avail ? head_len : 11'd0;

    // ------------------------------------------------------------------
    // Read side
    // ------------------------------------------------------------------
    assign rd_acc = rd_en & frame_avail;
    assign rd_end = rd_acc & (rd_cnt_reg == (head_len - 11'd1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_reg <= '0;
            rd_cnt_reg <= '0;
            rd_data    <= '0;
            rd_valid   <= 1'b0;
            rd_last    <= 1'b0;
        end else begin
            rd_valid <= rd_acc;
            rd_last  <= rd_end;
            if (rd_acc) begin
                rd_data    <= mem[rd_ptr_reg[ADDR_W-1:0]];
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
                rd_cnt_reg <= rd_end ? 11'd0 : (rd_cnt_reg + 11'd1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Statistics
    // ------------------------------------------------------------------
`ifdef RX_FRAME_STATS_EN
    logic [15:0] ok_cnt_reg, drop_cnt_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ok_cnt_reg   <= '0;
            drop_cnt_reg <= '0;
        end else begin
            if (good && (ok_cnt_reg != 16'hFFFF)) begin
                ok_cnt_reg <= ok_cnt_reg + 16'd1;
            end
            if (bad && (drop_cnt_reg != 16'hFFFF)) begin
                drop_cnt_reg <= drop_cnt_reg + 16'd1;
            end
        end
    end

    assign frames_ok      = ok_cnt_reg;
    assign frames_dropped = drop_cnt_reg;
`else
    assign frames_ok      = 16'd0;
    assign frames_dropped = 16'd0;
`endif

endmodule
